// File: rtl/pp_lane_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : pp_lane_accumulator
//  Description : Combines DIG_W x DIG_W partial products from the small
//                multiplier array into full products for NUM_LANES
//                independent lanes. Operands are 1, 2 or 4 digits wide and
//                take k*k beats, one per accepted cycle. The result can
//                optionally be accumulated into the previous result.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   clock
//    rst       in   asynchronous reset, ACTIVE-LOW
//    start     in   begin an operation (sampled only in IDLE)
//    mode      in   00=1 digit, 01=2 digits, 10=4 digits, 11=reserved
//    acc_en    in   sampled with start: add product to the previous result
//    pp_valid  in   partial products on pp_in are valid this beat
//    pp_in     in   per-lane partial product, lane n at [n*2*DIG_W +: 2*DIG_W]
//    sel_a     out  digit index i of operand A wanted this beat
//    sel_b     out  digit index j of operand B wanted this beat
//    busy      out  operation in progress
//    done      out  one-cycle pulse, result/ovf updated
//    err       out  one-cycle pulse after a start with mode=11
//    result    out  per-lane product, zero-extended, held until next done
//    ovf       out  per-lane accumulate carry-out, updates with done
// ============================================================================
module pp_lane_accumulator #(
    parameter  int NUM_LANES = 2,
    parameter  int DIG_W     = 8,
    localparam int RES_W     = 8 * DIG_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [1:0]                     mode,
    input  logic                           acc_en,
    input  logic                           pp_valid,
    input  logic [NUM_LANES*2*DIG_W-1:0]   pp_in,
    output logic [1:0]                     sel_a,
    output logic [1:0]                     sel_b,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [NUM_LANES*RES_W-1:0]     result,
    output logic [NUM_LANES-1:0]           ovf
);

    localparam int c_PP_W = 2 * DIG_W;
    localparam int c_SH_W = $clog2(RES_W);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCUM  = 2'd1;
    localparam logic [1:0] c_S_FINISH = 2'd2;

    localparam logic [1:0] c_MODE_K1  = 2'b00;
    localparam logic [1:0] c_MODE_K2  = 2'b01;
    localparam logic [1:0] c_MODE_K4  = 2'b10;
    localparam logic [1:0] c_MODE_RSV = 2'b11;

    // Product-width masks for 1, 2 and 4 digit operands.
    localparam logic [RES_W-1:0] c_MASK_K1 = {{(RES_W-c_PP_W){1'b0}}, {c_PP_W{1'b1}}};
    localparam logic [RES_W-1:0] c_MASK_K2 = {{(RES_W-2*c_PP_W){1'b0}}, {(2*c_PP_W){1'b1}}};
    localparam logic [RES_W-1:0] c_MASK_K4 = {RES_W{1'b1}};

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [1:0]        r_mode;      // latched digit-count code
    logic              r_acc_en;
    logic [3:0]        r_cnt;       // beat counter n = i*k + j
    logic              r_drain;     // last beat accepted, still in the pipe
    logic              r_pp_vld;    // r_pp_shift holds an unadded beat
    logic              r_done;
    logic              r_err;

    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_accept;
    logic              w_last;
    logic [1:0]        w_dig_i;
    logic [1:0]        w_dig_j;
    logic [2:0]        w_dsum;
    logic [c_SH_W-1:0] w_shamt;
    logic [RES_W-1:0]  w_mask;

    assign w_start_ok  = (r_state == c_S_IDLE) && start && (mode != c_MODE_RSV);
    assign w_start_bad = (r_state == c_S_IDLE) && start && (mode == c_MODE_RSV);
    // Once the final beat is taken, further valid beats are ignored while
    // the pipelined add drains.
    assign w_accept    = (r_state == c_S_ACCUM) && pp_valid && !r_drain;

    // Digit indices decode straight from the counter: j is the low
    // log2(k) bits, i the next log2(k) bits.
    always_comb begin
        w_dig_i = 2'd0;
        w_dig_j = 2'd0;
        w_last  = 1'b1;
        w_mask  = c_MASK_K1;
        case (r_mode)
            c_MODE_K2: begin
                w_dig_i = {1'b0, r_cnt[1]};
                w_dig_j = {1'b0, r_cnt[0]};
                w_last  = (r_cnt[1:0] == 2'b11);
                w_mask  = c_MASK_K2;
            end
            c_MODE_K4: begin
                w_dig_i = r_cnt[3:2];
                w_dig_j = r_cnt[1:0];
                w_last  = (r_cnt == 4'hF);
                w_mask  = c_MASK_K4;
            end
            default: begin
                w_dig_i = 2'd0;
                w_dig_j = 2'd0;
                w_last  = 1'b1;
                w_mask  = c_MASK_K1;
            end
        endcase
    end

    assign w_dsum  = {1'b0, w_dig_i} + {1'b0, w_dig_j};
    assign w_shamt = c_SH_W'(w_dsum) * c_SH_W'(DIG_W);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = c_S_ACCUM;
                end
            end
            c_S_ACCUM: begin
                // The drain cycle adds the final beat into the accumulator.
                if (r_drain) begin
                    w_next_state = c_S_FINISH;
                end
            end
            c_S_FINISH: begin
                w_next_state = c_S_IDLE;
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy  = (r_state == c_S_ACCUM) || (r_state == c_S_FINISH);
        sel_a = 2'd0;
        sel_b = 2'd0;
        if (r_state == c_S_ACCUM) begin
            sel_a = w_dig_i;
            sel_b = w_dig_j;
        end
    end

    assign done = r_done;
    assign err  = r_err;

    // ------------------------------------------------------------------
    // Beat sequencer and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode   <= c_MODE_K1;
            r_acc_en <= 1'b0;
            r_cnt    <= 4'd0;
            r_drain  <= 1'b0;
            r_pp_vld <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_mode   <= mode;
                r_acc_en <= acc_en;
                r_cnt    <= 4'd0;
                r_drain  <= 1'b0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 4'd1;
                if (w_last) begin
                    r_drain <= 1'b1;
                end
            end
            r_pp_vld <= w_accept;
            r_done   <= (r_state == c_S_FINISH);
            r_err    <= w_start_bad;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane datapath: shift -> register -> accumulate -> finalise
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [c_PP_W-1:0] w_pp_lane;
            logic [RES_W-1:0]  w_pp_shifted;
            logic [RES_W-1:0]  r_pp_shift;
            logic [RES_W-1:0]  r_acc;
            logic [RES_W-1:0]  r_res;
            logic              r_ovf;
            logic [RES_W-1:0]  w_prod;
            logic [RES_W-1:0]  w_old;
            logic [RES_W:0]    w_sum;
            logic              w_carry;

            assign w_pp_lane    = pp_in[gi*c_PP_W +: c_PP_W];
            assign w_pp_shifted = {{(RES_W-c_PP_W){1'b0}}, w_pp_lane} << w_shamt;

            // The shifted beat is registered before the add so the shifter
            // and the full-width adder sit in separate cycles.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pp_shift <= '0;
                    r_acc      <= '0;
                end else begin
                    if (w_accept) begin
                        r_pp_shift <= w_pp_shifted;
                    end
                    if (w_start_ok) begin
                        r_acc <= '0;
                    end else if (r_pp_vld) begin
                        r_acc <= r_acc + r_pp_shift;
                    end
                end
            end

            // Accumulate at the product width; the old result is trimmed to
            // that width so the carry reflects a k-digit wraparound.
            assign w_prod = r_acc & w_mask;
            assign w_old  = r_res & w_mask;
            assign w_sum  = {1'b0, w_old} + {1'b0, w_prod};

            always_comb begin
                case (r_mode)
                    c_MODE_K2: w_carry = w_sum[2*c_PP_W];
                    c_MODE_K4: w_carry = w_sum[RES_W];
                    default:   w_carry = w_sum[c_PP_W];
                endcase
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_res <= '0;
                    r_ovf <= 1'b0;
                end else if (r_state == c_S_FINISH) begin
                    if (r_acc_en) begin
                        r_res <= w_sum[RES_W-1:0] & w_mask;
                        r_ovf <= w_carry;
                    end else begin
                        r_res <= w_prod;
                        r_ovf <= 1'b0;
                    end
                end
            end

            assign result[gi*RES_W +: RES_W] = r_res;
            assign ovf[gi]                   = r_ovf;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pp_lane_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_lane_accumulator
//  Description : Directed self-checking bench for pp_lane_accumulator.
//                Expected results are computed from the operands (A*B per
//                lane, with optional accumulate) and queued at start, then
//                popped and compared when done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pp_lane_accumulator;

    localparam int c_LANES = 2;
    localparam int c_DIG_W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   mode;
    logic         acc_en;
    logic         pp_valid;
    logic [31:0]  pp_in;
    logic [1:0]   sel_a;
    logic [1:0]   sel_b;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] result;
    logic [1:0]   ovf;

    typedef struct packed {
        logic [127:0] res;
        logic [1:0]   ovf;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model_res [c_LANES];
    int          n_tests;
    int          n_fail;

    pp_lane_accumulator #(
        .NUM_LANES (c_LANES),
        .DIG_W     (c_DIG_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .acc_en   (acc_en),
        .pp_valid (pp_valid),
        .pp_in    (pp_in),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one operation starting in the current (IDLE or done) cycle.
    task automatic do_op(input logic [1:0] m, input logic ae,
                         input logic [63:0] aop, input logic [63:0] bop,
                         input bit stall3, input bit start_noise);
        int          k;
        int          kk;
        int          n;
        int          c;
        int          bi;
        int          bj;
        logic [31:0] av;
        logic [31:0] bv;
        logic [63:0] msk;
        logic [63:0] p;
        logic [64:0] s;
        logic [15:0] pl [c_LANES];
        exp_t        e;
        k   = (m == 2'b00) ? 1 : ((m == 2'b01) ? 2 : 4);
        kk  = k * k;
        msk = (k == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (16 * k)) - 64'd1);
        e   = '0;
        for (int l = 0; l < c_LANES; l++) begin
            av = aop[l*32 +: 32];
            bv = bop[l*32 +: 32];
            p  = (64'(av) * 64'(bv)) & msk;
            if (ae) begin
                s = {1'b0, model_res[l] & msk} + {1'b0, p};
                e.ovf[l]          = s[16*k];
                e.res[l*64 +: 64] = s[63:0] & msk;
            end else begin
                e.ovf[l]          = 1'b0;
                e.res[l*64 +: 64] = p;
            end
            model_res[l] = e.res[l*64 +: 64];
        end
        sb_q.push_back(e);

        start  = 1'b1;
        mode   = m;
        acc_en = ae;
        tick();
        start  = 1'b0;
        acc_en = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1'b1));

        n = 0;
        c = 0;
        while (n < kk && c < 200) begin
            bi = n / k;
            bj = n % k;
            chk("sel_a", 128'(sel_a), 128'(bi));
            chk("sel_b", 128'(sel_b), 128'(bj));
            if (stall3 && (c % 3 == 2)) begin
                pp_valid = 1'b0;
                pp_in    = $urandom;
            end else begin
                for (int l = 0; l < c_LANES; l++) begin
                    pl[l] = 16'(aop[l*32 + 8*bi +: 8]) * 16'(bop[l*32 + 8*bj +: 8]);
                end
                pp_valid = 1'b1;
                pp_in    = {pl[1], pl[0]};
                n++;
            end
            start = start_noise;
            tick();
            c++;
        end
        chk("beats_supplied", 128'(n), 128'(kk));

        // Junk beats after the last one must be ignored.
        start    = 1'b0;
        pp_valid = 1'b1;
        pp_in    = 32'hFFFF_FFFF;
        chk("done_lat0", 128'(done), 128'(1'b0));
        tick();
        chk("done_lat1", 128'(done), 128'(1'b0));
        chk("busy_finish", 128'(busy), 128'(1'b1));
        tick();
        pp_valid = 1'b0;
        chk("done_lat2", 128'(done), 128'(1'b1));
        chk("busy_in_done", 128'(busy), 128'(1'b0));
        if (sb_q.size() == 0) begin
            chk("sb_empty", 128'(1'b1), 128'(1'b0));
        end else begin
            e = sb_q.pop_front();
            chk("result", result, e.res);
            chk("ovf", 128'(ovf), 128'(e.ovf));
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
        acc_en   = 1'b0;
        pp_valid = 1'b0;
        pp_in    = '0;
        for (int l = 0; l < c_LANES; l++) model_res[l] = '0;

        // Reset state
        tick();
        tick();
        chk("rst_result", result, 128'd0);
        chk("rst_ovf", 128'(ovf), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_sel", 128'({sel_a, sel_b}), 128'd0);
        rst = 1'b1;
        tick();
        // pp_valid in IDLE without start is ignored
        pp_valid = 1'b1;
        pp_in    = 32'hFFFF_FFFF;
        tick();
        pp_valid = 1'b0;
        chk("idle_busy", 128'(busy), 128'd0);
        chk("idle_done", 128'(done), 128'd0);

        // 1 digit: lane0 0xFF*0x01, lane1 0x05*0x07
        do_op(2'b00, 1'b0, {32'h05, 32'hFF}, {32'h07, 32'h01}, 1'b0, 1'b0);
        tick();
        chk("done_one_cycle", 128'(done), 128'd0);
        chk("busy_low_after", 128'(busy), 128'd0);

        // 2 digits, start held high during ACCUM (must be ignored)
        do_op(2'b01, 1'b0, {32'hBEEF, 32'h1234}, {32'hCAFE, 32'h5678}, 1'b0, 1'b1);
        // 4 digits, every third cycle stalled, started in the done cycle
        do_op(2'b10, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1'b1, 1'b0);
        // Base value 0xFF for the accumulate chain
        do_op(2'b00, 1'b0, {32'h80, 32'hFF}, {32'h80, 32'h01}, 1'b0, 1'b0);
        // Accumulate 0xFE01 twice: no carry, then carry
        do_op(2'b00, 1'b1, {32'hFF, 32'hFF}, {32'hFF, 32'hFF}, 1'b0, 1'b0);
        do_op(2'b00, 1'b1, {32'hFF, 32'hFF}, {32'hFF, 32'hFF}, 1'b0, 1'b0);
        // Accumulate at 2 digits onto a narrower previous result
        do_op(2'b01, 1'b1, {32'hFFFF, 32'h1234}, {32'hFFFF, 32'h5678}, 1'b1, 1'b0);

        // Reserved mode, issued in the done cycle
        start = 1'b1;
        mode  = 2'b11;
        tick();
        start = 1'b0;
        chk("err_pulse", 128'(err), 128'd1);
        chk("err_busy", 128'(busy), 128'd0);
        chk("err_done", 128'(done), 128'd0);
        tick();
        chk("err_one_cycle", 128'(err), 128'd0);
        chk("err_stay_idle", 128'(busy), 128'd0);

        // Abort a 4-digit operation after 5 beats
        start = 1'b1;
        mode  = 2'b10;
        tick();
        start    = 1'b0;
        pp_valid = 1'b1;
        pp_in    = 32'h1234_5678;
        for (int b = 0; b < 5; b++) tick();
        chk("abort_sel_b", 128'(sel_b), 128'd1);
        rst = 1'b0;
        #2;
        chk("abort_result", result, 128'd0);
        chk("abort_ovf", 128'(ovf), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_sel", 128'({sel_a, sel_b}), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        pp_valid = 1'b0;
        for (int l = 0; l < c_LANES; l++) model_res[l] = '0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("abort_no_done", 128'(done), 128'd0);

        // Fresh operation after reset, accumulating onto the cleared result
        do_op(2'b00, 1'b1, {32'h11, 32'hAB}, {32'h22, 32'hCD}, 1'b0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
